// File: rtl/traffic_light_monitor_if.sv
// traffic_light_monitor_if
// Bundles the lamp/pass signals seen by the traffic light monitor together
// with the decoded status the monitor reports back.
//
// Signals:
//   pass, r, g, y  - controller pass request and lamp outputs
//   phase          - decoded phase (0 G1 .. 6 R, 7 UNSYNC)
//   phase_valid    - high while phase is not UNSYNC
//   run_len        - samples counted in the current phase (CW bits)
//   err_pulse      - one-cycle pulse per detected violation
//   err            - sticky error flag
//   err_code       - most recent violation: 1 ILLEGAL, 2 SHORT, 3 LONG
//   cycle_cnt      - completed R->G1 wraps
//
// Modports:
//   master - the side that drives the lamps (controller or bench)
//   slave  - the monitor itself
interface traffic_light_monitor_if #(
   parameter int CW = 11
);
   logic          pass;
   logic          r;
   logic          g;
   logic          y;
   logic [2:0]    phase;
   logic          phase_valid;
   logic [CW-1:0] run_len;
   logic          err_pulse;
   logic          err;
   logic [1:0]    err_code;
   logic [15:0]   cycle_cnt;

   modport master (
      output pass, r, g, y,
      input  phase, phase_valid, run_len, err_pulse, err, err_code, cycle_cnt
   );

   modport slave (
      input  pass, r, g, y,
      output phase, phase_valid, run_len, err_pulse, err, err_code, cycle_cnt
   );
endinterface

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Passive checker beside the traffic light controller. It decodes the lamp
// pattern {r,g,y} back into the controller phase, counts how many samples
// each phase lasts, and flags out-of-order patterns, phases that end early
// (SHORT) and phases that run too long (LONG). After a violation it sits in
// UNSYNC until it sees R followed by G, or until a pass request.
//
// Optional feature: define TL_MON_CYCLE_CNT_EN to build the 16-bit count of
// completed R->G1 wraps; otherwise cycle_cnt is tied to 0.
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous, active-high reset
//   mon  - traffic_light_monitor_if.slave: pass/r/g/y in, status out
//
// Parameters: T_G1, T_X, T_G2, T_G3, T_Y, T_R are phase lengths in samples;
// CW is the run-length width and must match the interface's CW and hold the
// largest phase length.
module traffic_light_monitor #(
   parameter int T_G1 = 1024,
   parameter int T_X  = 128,
   parameter int T_G2 = 128,
   parameter int T_G3 = 128,
   parameter int T_Y  = 512,
   parameter int T_R  = 1024,
   parameter int CW   = 11
) (
   input logic                     clk,
   input logic                     rst,
   traffic_light_monitor_if.slave  mon
);

   typedef enum logic [2:0] {
      PH_G1     = 3'd0,
      PH_X1     = 3'd1,
      PH_G2     = 3'd2,
      PH_X2     = 3'd3,
      PH_G3     = 3'd4,
      PH_Y      = 3'd5,
      PH_R      = 3'd6,
      PH_UNSYNC = 3'd7
   } phase_t;

   localparam logic [2:0] PAT_G = 3'b010;
   localparam logic [2:0] PAT_X = 3'b000;
   localparam logic [2:0] PAT_Y = 3'b001;
   localparam logic [2:0] PAT_R = 3'b100;

   localparam logic [1:0] CODE_ILLEGAL = 2'd1;
   localparam logic [1:0] CODE_SHORT   = 2'd2;
   localparam logic [1:0] CODE_LONG    = 2'd3;

   localparam logic [CW-1:0] RUN_ONE = {{(CW-1){1'b0}}, 1'b1};

   // Lamp pattern the controller shows during a given phase.
   function automatic logic [2:0] phasePattern(input phase_t ph);
      case (ph)
         PH_G1, PH_G2, PH_G3: return PAT_G;
         PH_X1, PH_X2:        return PAT_X;
         PH_Y:                return PAT_Y;
         default:             return PAT_R;
      endcase
   endfunction

   // Successor in the fixed cycle G1 X1 G2 X2 G3 Y R.
   function automatic phase_t phaseAfter(input phase_t ph);
      case (ph)
         PH_G1:   return PH_X1;
         PH_X1:   return PH_G2;
         PH_G2:   return PH_X2;
         PH_X2:   return PH_G3;
         PH_G3:   return PH_Y;
         PH_Y:    return PH_R;
         PH_R:    return PH_G1;
         default: return PH_UNSYNC;
      endcase
   endfunction

   // Required length of a phase, one bit wider than run_len so the
   // incremented count can be compared without wrapping.
   function automatic logic [CW:0] phaseLimit(input phase_t ph);
      case (ph)
         PH_G1:   return (CW+1)'(T_G1);
         PH_X1:   return (CW+1)'(T_X);
         PH_G2:   return (CW+1)'(T_G2);
         PH_X2:   return (CW+1)'(T_X);
         PH_G3:   return (CW+1)'(T_G3);
         PH_Y:    return (CW+1)'(T_Y);
         PH_R:    return (CW+1)'(T_R);
         default: return '0;
      endcase
   endfunction

   phase_t        phase_q, phase_d;
   logic [CW-1:0] run_len_q, run_len_d;
   logic [2:0]    prev_q;
   logic          err_q, err_d;
   logic          err_pulse_q, err_pulse_d;
   logic [1:0]    err_code_q, err_code_d;
   logic [2:0]    sample;
   logic [CW:0]   runInc;
   logic          errRaise;
   logic [1:0]    errKind;

   assign sample = {mon.r, mon.g, mon.y};
   assign runInc = {1'b0, run_len_q} + {{CW{1'b0}}, 1'b1};

   // Phase tracking. While synced the sample must either continue the
   // current phase (within its limit) or start the next one exactly at the
   // limit; anything else is a violation. The branches are mutually
   // exclusive, so at most one error is raised per edge. A pass request
   // truncates any phase other than G1 legally and restarts G1 at zero so
   // that the controller's first green sample counts as 1. In UNSYNC the
   // monitor only watches for an R->G edge or a pass request.
   always_comb begin
      phase_d   = phase_q;
      run_len_d = run_len_q;
      errRaise  = 1'b0;
      errKind   = 2'd0;

      if (phase_q != PH_UNSYNC) begin
         if (sample == phasePattern(phase_q)) begin
            if (runInc > phaseLimit(phase_q)) begin
               errRaise  = 1'b1;
               errKind   = CODE_LONG;
               phase_d   = PH_UNSYNC;
               run_len_d = '0;
            end else begin
               run_len_d = runInc[CW-1:0];
            end
         end else if (sample == phasePattern(phaseAfter(phase_q))) begin
            if ({1'b0, run_len_q} == phaseLimit(phase_q)) begin
               phase_d   = phaseAfter(phase_q);
               run_len_d = RUN_ONE;
            end else begin
               errRaise  = 1'b1;
               errKind   = CODE_SHORT;
               phase_d   = PH_UNSYNC;
               run_len_d = '0;
            end
         end else begin
            errRaise  = 1'b1;
            errKind   = CODE_ILLEGAL;
            phase_d   = PH_UNSYNC;
            run_len_d = '0;
         end

         if (mon.pass && (phase_d != PH_G1) && (phase_d != PH_UNSYNC)) begin
            phase_d   = PH_G1;
            run_len_d = '0;
         end
      end else begin
         if ((sample == PAT_G) && (prev_q == PAT_R)) begin
            phase_d   = PH_G1;
            run_len_d = RUN_ONE;
         end
         if (mon.pass) begin
            phase_d   = PH_G1;
            run_len_d = '0;
         end
      end
   end

   // Error reporting: the pulse mirrors this edge's violation, the flag is
   // sticky until reset and the code keeps the most recent violation.
   always_comb begin
      err_pulse_d = errRaise;
      err_d       = err_q | errRaise;
      err_code_d  = errRaise ? errKind : err_code_q;
   end

   // State registers. The previous-sample register starts at the green
   // pattern so a reset can never look like an R->G edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q     <= PH_G1;
         run_len_q   <= '0;
         prev_q      <= PAT_G;
         err_q       <= 1'b0;
         err_pulse_q <= 1'b0;
         err_code_q  <= 2'd0;
      end else begin
         phase_q     <= phase_d;
         run_len_q   <= run_len_d;
         prev_q      <= sample;
         err_q       <= err_d;
         err_pulse_q <= err_pulse_d;
         err_code_q  <= err_code_d;
      end
   end

`ifdef TL_MON_CYCLE_CNT_EN
   logic [15:0] cycle_cnt_q, cycle_cnt_d;
   logic        wrapEdge;

   // A wrap is a legal R->G1 advance: synced in R, full length reached and
   // green sampled. A pass on that same edge leaves the phase at G1, so it
   // does not cancel the count.
   always_comb begin
      wrapEdge    = (phase_q == PH_R) && (sample == PAT_G) &&
                    ({1'b0, run_len_q} == phaseLimit(PH_R));
      cycle_cnt_d = wrapEdge ? cycle_cnt_q + 16'd1 : cycle_cnt_q;
   end

   // Wrap counter register, free-running modulo 2^16.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt_q <= 16'd0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
      end
   end

   assign mon.cycle_cnt = cycle_cnt_q;
`else
   assign mon.cycle_cnt = 16'd0;
`endif

   assign mon.phase       = phase_q;
   assign mon.phase_valid = (phase_q != PH_UNSYNC);
   assign mon.run_len     = run_len_q;
   assign mon.err_pulse   = err_pulse_q;
   assign mon.err         = err_q;
   assign mon.err_code    = err_code_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor
// Bench for traffic_light_monitor with default phase lengths. A behavioural
// model built from phase tables (pattern and length per phase index, modulo-7
// succession) predicts every output after every sample. Directed sequences
// cover reset, conforming cycles, LONG/SHORT/ILLEGAL, pass and mid-run reset;
// then a randomized controller emits mostly conforming traffic with random
// short/long phases, illegal patterns, pass requests and resets.
module tb_traffic_light_monitor;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   traffic_light_monitor_if #(.CW(11)) monIf ();

   traffic_light_monitor dut (
      .clk (clk),
      .rst (rst),
      .mon (monIf)
   );

`ifdef TL_MON_CYCLE_CNT_EN
   localparam bit CC_EN = 1'b1;
`else
   localparam bit CC_EN = 1'b0;
`endif

   localparam logic [2:0] P_G = 3'b010;
   localparam logic [2:0] P_X = 3'b000;
   localparam logic [2:0] P_Y = 3'b001;
   localparam logic [2:0] P_R = 3'b100;

   int         DUR [7] = '{1024, 128, 128, 128, 128, 512, 1024};
   logic [2:0] PAT [7] = '{3'b010, 3'b000, 3'b010, 3'b000, 3'b010, 3'b001, 3'b100};
   logic [2:0] ILL [4] = '{3'b011, 3'b101, 3'b110, 3'b111};

   int checkCount = 0;
   int errorCount = 0;

   // Reference model state
   bit         mSynced;
   int         mIdx;
   int         mRun;
   int         mCycles;
   logic [2:0] mPrev;
   bit         mErr;
   bit         mPulse;
   int         mCode;

   // Randomized controller state
   int ctrlIdx;
   int ctrlCnt;
   int ctrlTarget;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
         if (errorCount >= 50) begin
            $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
            $finish;
         end
      end
   endtask

   task automatic modelReset();
      mSynced = 1'b1;
      mIdx    = 0;
      mRun    = 0;
      mCycles = 0;
      mPrev   = P_G;
      mErr    = 1'b0;
      mPulse  = 1'b0;
      mCode   = 0;
   endtask

   task automatic modelRaise(input int code);
      mSynced = 1'b0;
      mRun    = 0;
      mErr    = 1'b1;
      mPulse  = 1'b1;
      mCode   = code;
   endtask

   task automatic modelStep(input logic [2:0] pat, input bit ps);
      bit wasSynced;
      int nxt;
      wasSynced = mSynced;
      mPulse    = 1'b0;
      nxt       = (mIdx + 1) % 7;
      if (wasSynced) begin
         if (pat == PAT[mIdx]) begin
            mRun++;
            if (mRun > DUR[mIdx]) modelRaise(3);
         end else if (pat == PAT[nxt]) begin
            if (mRun == DUR[mIdx]) begin
               if (mIdx == 6) mCycles++;
               mIdx = nxt;
               mRun = 1;
            end else begin
               modelRaise(2);
            end
         end else begin
            modelRaise(1);
         end
         if (ps && mSynced && mIdx != 0) begin
            mIdx = 0;
            mRun = 0;
         end
      end else begin
         if (pat == P_G && mPrev == P_R) begin
            mSynced = 1'b1;
            mIdx    = 0;
            mRun    = 1;
         end
         if (ps) begin
            mSynced = 1'b1;
            mIdx    = 0;
            mRun    = 0;
         end
      end
      mPrev = pat;
   endtask

   task automatic compareAll();
      checkOutput("phase",       32'(monIf.phase),       32'(mSynced ? mIdx : 7));
      checkOutput("phase_valid", 32'(monIf.phase_valid), 32'(mSynced));
      checkOutput("run_len",     32'(monIf.run_len),     32'(mSynced ? mRun : 0));
      checkOutput("err",         32'(monIf.err),         32'(mErr));
      checkOutput("err_pulse",   32'(monIf.err_pulse),   32'(mPulse));
      checkOutput("err_code",    32'(monIf.err_code),    32'(mCode));
      checkOutput("cycle_cnt",   32'(monIf.cycle_cnt),   CC_EN ? 32'(mCycles % 65536) : 32'd0);
   endtask

   task automatic applyStimulus(input logic [2:0] pat, input bit ps);
      monIf.r    = pat[2];
      monIf.g    = pat[1];
      monIf.y    = pat[0];
      monIf.pass = ps;
      @(posedge clk);
      modelStep(pat, ps);
      #1;
      compareAll();
      monIf.pass = 1'b0;
   endtask

   task automatic doReset();
      rst        = 1'b1;
      monIf.r    = 1'b1;
      monIf.g    = 1'b0;
      monIf.y    = 1'b0;
      monIf.pass = 1'b0;
      @(posedge clk);
      modelReset();
      #1;
      rst = 1'b0;
      compareAll();
   endtask

   task automatic runPattern(input logic [2:0] pat, input int n);
      for (int i = 0; i < n; i++) applyStimulus(pat, 1'b0);
   endtask

   task automatic runPhases(input int first, input int last);
      for (int k = first; k <= last; k++) runPattern(PAT[k], DUR[k]);
   endtask

   function automatic int pickTarget(input int k);
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 5)  return int'($urandom_range(1, DUR[k] - 1));
      if (sel < 10) return DUR[k] + int'($urandom_range(1, 40));
      return DUR[k];
   endfunction

   initial begin
      int savedCycles;
      logic [2:0] pat;
      bit ps;

      // Reset state
      doReset();
      checkOutput("rst_phase",     32'(monIf.phase),     32'd0);
      checkOutput("rst_run_len",   32'(monIf.run_len),   32'd0);
      checkOutput("rst_err",       32'(monIf.err),       32'd0);
      checkOutput("rst_err_code",  32'(monIf.err_code),  32'd0);
      checkOutput("rst_cycle_cnt", 32'(monIf.cycle_cnt), 32'd0);

      // Two conforming cycles, then the wrap sample into G1
      for (int c = 0; c < 2; c++) runPhases(0, 6);
      checkOutput("conf_phase_r", 32'(monIf.phase),   32'd6);
      checkOutput("conf_run_r",   32'(monIf.run_len), 32'd1024);
      checkOutput("conf_err",     32'(monIf.err),     32'd0);
      applyStimulus(P_G, 1'b0);
      checkOutput("conf_wrap_phase", 32'(monIf.phase),     32'd0);
      checkOutput("conf_wrap_run",   32'(monIf.run_len),   32'd1);
      checkOutput("conf_cycle_cnt",  32'(monIf.cycle_cnt), CC_EN ? 32'd2 : 32'd0);

      // Green held for 1025 samples -> LONG
      runPattern(P_G, 1023);
      applyStimulus(P_G, 1'b0);
      checkOutput("long_pulse", 32'(monIf.err_pulse), 32'd1);
      checkOutput("long_code",  32'(monIf.err_code),  32'd3);
      checkOutput("long_phase", 32'(monIf.phase),     32'd7);
      applyStimulus(P_G, 1'b0);
      checkOutput("long_pulse_drop", 32'(monIf.err_pulse), 32'd0);
      applyStimulus(P_R, 1'b0);
      applyStimulus(P_G, 1'b0);
      checkOutput("resync_phase", 32'(monIf.phase),   32'd0);
      checkOutput("resync_run",   32'(monIf.run_len), 32'd1);

      // Yellow lasting 300 samples -> SHORT
      runPattern(P_G, 1023);
      runPhases(1, 4);
      runPattern(P_Y, 300);
      applyStimulus(P_R, 1'b0);
      checkOutput("short_code",  32'(monIf.err_code), 32'd2);
      checkOutput("short_phase", 32'(monIf.phase),    32'd7);

      // 110 during G2 -> ILLEGAL, err stays sticky
      applyStimulus(P_G, 1'b0);
      runPattern(P_G, 1023);
      runPattern(P_X, 128);
      runPattern(P_G, 10);
      applyStimulus(3'b110, 1'b0);
      checkOutput("illegal_code",  32'(monIf.err_code), 32'd1);
      checkOutput("illegal_phase", 32'(monIf.phase),    32'd7);
      runPattern(P_G, 5);
      checkOutput("err_sticky", 32'(monIf.err), 32'd1);

      // Pass at Y run_len 200, then pass during G1
      applyStimulus(P_R, 1'b0);
      applyStimulus(P_G, 1'b0);
      runPattern(P_G, 1023);
      runPhases(1, 4);
      runPattern(P_Y, 200);
      savedCycles = mCycles;
      applyStimulus(P_Y, 1'b1);
      checkOutput("pass_phase",  32'(monIf.phase),     32'd0);
      checkOutput("pass_run",    32'(monIf.run_len),   32'd0);
      checkOutput("pass_pulse",  32'(monIf.err_pulse), 32'd0);
      checkOutput("pass_cycles", 32'(monIf.cycle_cnt), CC_EN ? 32'(savedCycles) : 32'd0);
      applyStimulus(P_G, 1'b0);
      checkOutput("pass_first_g", 32'(monIf.run_len), 32'd1);
      applyStimulus(P_G, 1'b1);
      checkOutput("pass_in_g1", 32'(monIf.run_len), 32'd2);

      // Reset mid-R at run_len 700
      runPattern(P_G, 1022);
      runPhases(1, 5);
      runPattern(P_R, 700);
      checkOutput("midr_run", 32'(monIf.run_len), 32'd700);
      doReset();
      checkOutput("midr_rst_phase",  32'(monIf.phase),     32'd0);
      checkOutput("midr_rst_run",    32'(monIf.run_len),   32'd0);
      checkOutput("midr_rst_err",    32'(monIf.err),       32'd0);
      checkOutput("midr_rst_cycles", 32'(monIf.cycle_cnt), 32'd0);

      // Randomized controller traffic
      ctrlIdx    = 0;
      ctrlCnt    = 0;
      ctrlTarget = DUR[0];
      for (int i = 0; i < 40000; i++) begin
         if (ctrlCnt >= ctrlTarget) begin
            ctrlIdx    = (ctrlIdx + 1) % 7;
            ctrlCnt    = 0;
            ctrlTarget = pickTarget(ctrlIdx);
         end
         pat = PAT[ctrlIdx];
         if ($urandom_range(0, 3999) == 0) pat = ILL[$urandom_range(0, 3)];
         ps = ($urandom_range(0, 2999) == 0);
         applyStimulus(pat, ps);
         ctrlCnt++;
         if (ps) begin
            ctrlIdx    = 0;
            ctrlCnt    = 0;
            ctrlTarget = DUR[0];
         end
         if ($urandom_range(0, 19999) == 0) begin
            doReset();
            ctrlIdx    = 0;
            ctrlCnt    = 0;
            ctrlTarget = DUR[0];
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
